// File: rtl/nios2_oci_trace_capture.sv
// Debug trace capture FIFO. Frames of {count, buffer} are queued while
// capturing. When the test starts ending, capture stops and the queued
// frames drain to the consumer. Once the test has ended and the FIFO is
// empty, the block parks in DONE until reset. Frames that arrive while
// the FIFO is full are dropped and counted in a saturating counter.
module nios2_oci_trace_capture #(
   parameter int DCT_W = 30,
   parameter int CNT_W = 4,
   parameter int DEPTH = 16,
   parameter int OVF_W = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [DCT_W-1:0]         dct_buffer,
   input  logic [CNT_W-1:0]         dct_count,
   input  logic                     dct_valid,
   input  logic                     test_ending,
   input  logic                     test_has_ended,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CNT_W+DCT_W-1:0]   out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [OVF_W-1:0]         drop_count,
   output logic [1:0]               state,
   output logic                     done
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int FRAME_W = CNT_W + DCT_W;
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_stateNext;
   logic                 r_ended;
   logic                 w_endedNext;
   logic [FRAME_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]     r_wrPtr;
   logic [PTR_W-1:0]     r_rdPtr;
   logic [LVL_W-1:0]     r_level;
   logic [LVL_W-1:0]     w_levelNext;
   logic                 r_overflow;
   logic [OVF_W-1:0]     r_dropCount;
   logic                 w_notEmpty;
   logic                 w_full;
   logic                 w_pushReq;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_drop;

   assign w_notEmpty = (r_level != '0);
   assign w_full     = (r_level == FULL_LEVEL);

   // Zero-count frames carry no trace slots, so they are neither stored nor
   // counted as drops. A full FIFO still accepts a frame if the head leaves
   // in the same cycle.
   assign w_pushReq = dct_valid && (dct_count != '0) && (r_state == ST_CAPTURE);
   assign w_pop     = w_notEmpty && out_ready;
   assign w_push    = w_pushReq && (!w_full || w_pop);
   assign w_drop    = w_pushReq && w_full && !w_pop;

   // Occupancy after this cycle's push and pop, also used by the FSM so
   // DONE is reached on the same edge the last frame leaves.
   always_comb begin
      w_levelNext = r_level;
      case ({w_push, w_pop})
         2'b10:   w_levelNext = r_level + 1'b1;
         2'b01:   w_levelNext = r_level - 1'b1;
         default: w_levelNext = r_level;
      endcase
   end

   // Next-state logic; test_has_ended is remembered so a short pulse seen
   // while frames are still queued is not lost.
   always_comb begin
      w_stateNext = r_state;
      w_endedNext = r_ended | test_has_ended;
      case (r_state)
         ST_CAPTURE: begin
            if (test_ending || test_has_ended) begin
               w_stateNext = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_endedNext && (w_levelNext == '0)) begin
               w_stateNext = ST_DONE;
            end
         end
         ST_DONE: begin
            w_stateNext = ST_DONE;
         end
         default: begin
            w_stateNext = ST_CAPTURE;
         end
      endcase
   end

   // State register, pointers, occupancy and drop accounting.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_CAPTURE;
         r_ended     <= 1'b0;
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_dropCount <= '0;
      end else begin
         r_state <= w_stateNext;
         r_ended <= w_endedNext;
         r_level <= w_levelNext;
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropCount != '1) begin
               r_dropCount <= r_dropCount + 1'b1;
            end
         end
      end
   end

   // Frame storage; contents are never cleared because the head is masked
   // whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (reset_n && w_push) begin
         r_mem[r_wrPtr] <= {dct_count, dct_buffer};
      end
   end

   assign out_valid  = w_notEmpty;
   assign out_data   = w_notEmpty ? r_mem[r_rdPtr] : '0;
   assign level      = r_level;
   assign overflow   = r_overflow;
   assign drop_count = r_dropCount;
   assign state      = r_state;
   assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed testbench for the trace capture FIFO. A second instance with a
// 2-bit drop counter shares the stimulus to exercise counter saturation.
module tb_nios2_oci_trace_capture;

   localparam int DCT_W = 30;
   localparam int CNT_W = 4;
   localparam int DEPTH = 16;
   localparam int FW    = CNT_W + DCT_W;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [DCT_W-1:0] dct_buffer;
   logic [CNT_W-1:0] dct_count;
   logic             dct_valid;
   logic             test_ending;
   logic             test_has_ended;
   logic             out_ready;

   logic             out_valid;
   logic [FW-1:0]    out_data;
   logic [4:0]       level;
   logic             overflow;
   logic [7:0]       drop_count;
   logic [1:0]       state;
   logic             done;

   logic             out_valid2;
   logic [FW-1:0]    out_data2;
   logic [4:0]       level2;
   logic             overflow2;
   logic [1:0]       drop_count2;
   logic [1:0]       state2;
   logic             done2;

   int checks   = 0;
   int failures = 0;

   nios2_oci_trace_capture #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
      .overflow(overflow), .drop_count(drop_count), .state(state), .done(done)
   );

   nios2_oci_trace_capture #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .level(level2),
      .overflow(overflow2), .drop_count(drop_count2), .state(state2), .done(done2)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Watchdog so a broken design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout reached");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [FW-1:0] mkFrame(input int c, input int b);
      logic [CNT_W-1:0] cc;
      logic [DCT_W-1:0] bb;
      cc = CNT_W'(c);
      bb = DCT_W'(b);
      return {cc, bb};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset_n        = 1'b0;
      dct_valid      = 1'b0;
      dct_count      = '0;
      dct_buffer     = '0;
      test_ending    = 1'b0;
      test_has_ended = 1'b0;
      out_ready      = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   // Push n frames with count (i%15)+1 and buffer base+i, consumer stalled.
   task automatic pushFrames(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         dct_valid  = 1'b1;
         dct_count  = CNT_W'((i % 15) + 1);
         dct_buffer = DCT_W'(base + i);
         tick();
      end
      dct_valid = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
      checks++; if (level !== 5'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== '0) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_ovf got=%b/%0d exp=0/0", overflow, drop_count); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
   endtask

   task automatic test_basic();
      doReset();
      for (int i = 1; i <= 3; i++) begin
         dct_valid  = 1'b1;
         dct_count  = CNT_W'(i);
         dct_buffer = DCT_W'(i);
         if (i == 1) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_no_fallthrough got=%b exp=0", out_valid); end
         end
         tick();
         if (i == 1) begin
            checks++; if (out_data !== mkFrame(1, 1)) begin failures++; $display("[TB] FAIL basic_latency got=%h exp=%h", out_data, mkFrame(1, 1)); end
         end
      end
      dct_valid = 1'b0;
      tick();
      checks++; if (level !== 5'd3) begin failures++; $display("[TB] FAIL basic_level got=%0d exp=3", level); end
      checks++; if (out_data !== mkFrame(1, 1)) begin failures++; $display("[TB] FAIL basic_head_stable got=%h exp=%h", out_data, mkFrame(1, 1)); end
      out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         checks++; if (out_data !== mkFrame(i, i)) begin failures++; $display("[TB] FAIL basic_pop%0d got=%h exp=%h", i, out_data, mkFrame(i, i)); end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_empty got=%0d/%b exp=0/0", level, out_valid); end
      checks++; if (out_data !== '0) begin failures++; $display("[TB] FAIL basic_empty_data got=%h exp=0", out_data); end
   endtask

   task automatic test_overflow();
      doReset();
      pushFrames(20, 0);
      checks++; if (level !== 5'd16) begin failures++; $display("[TB] FAIL ovf_level got=%0d exp=16", level); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
      checks++; if (drop_count !== 8'd4) begin failures++; $display("[TB] FAIL ovf_drops got=%0d exp=4", drop_count); end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (out_data !== mkFrame((i % 15) + 1, i)) begin failures++; $display("[TB] FAIL ovf_order%0d got=%h exp=%h", i, out_data, mkFrame((i % 15) + 1, i)); end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (level !== 5'd0) begin failures++; $display("[TB] FAIL ovf_drained got=%0d exp=0", level); end
      checks++; if (overflow !== 1'b1 || drop_count !== 8'd4) begin failures++; $display("[TB] FAIL ovf_sticky got=%b/%0d exp=1/4", overflow, drop_count); end
   endtask

   task automatic test_full_pushpop();
      doReset();
      pushFrames(16, 100);
      checks++; if (level !== 5'd16) begin failures++; $display("[TB] FAIL fpp_full got=%0d exp=16", level); end
      dct_valid  = 1'b1;
      dct_count  = 4'd5;
      dct_buffer = DCT_W'('h3FF);
      out_ready  = 1'b1;
      tick();
      dct_valid = 1'b0;
      checks++; if (level !== 5'd16) begin failures++; $display("[TB] FAIL fpp_level got=%0d exp=16", level); end
      checks++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL fpp_nodrop got=%b/%0d exp=0/0", overflow, drop_count); end
      for (int k = 0; k < 16; k++) begin
         logic [FW-1:0] exp;
         exp = (k < 15) ? mkFrame(((k + 1) % 15) + 1, 101 + k) : mkFrame(5, 'h3FF);
         checks++; if (out_data !== exp) begin failures++; $display("[TB] FAIL fpp_order%0d got=%h exp=%h", k, out_data, exp); end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (level !== 5'd0) begin failures++; $display("[TB] FAIL fpp_drained got=%0d exp=0", level); end
   endtask

   task automatic test_drain();
      doReset();
      for (int i = 0; i < 5; i++) begin
         dct_valid   = 1'b1;
         dct_count   = CNT_W'(i + 1);
         dct_buffer  = DCT_W'(50 + i);
         test_ending = (i == 4);
         tick();
      end
      test_ending = 1'b0;
      checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL drain_enter got=%0d exp=1", state); end
      checks++; if (level !== 5'd5) begin failures++; $display("[TB] FAIL drain_last_push got=%0d exp=5", level); end
      repeat (3) tick();
      checks++; if (level !== 5'd5) begin failures++; $display("[TB] FAIL drain_no_push got=%0d exp=5", level); end
      test_has_ended = 1'b1;
      tick();
      test_has_ended = 1'b0;
      checks++; if (state !== 2'd1 || done !== 1'b0) begin failures++; $display("[TB] FAIL drain_hold got=%0d/%b exp=1/0", state, done); end
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         logic [1:0] expState;
         checks++; if (out_data !== mkFrame(k + 1, 50 + k)) begin failures++; $display("[TB] FAIL drain_order%0d got=%h exp=%h", k, out_data, mkFrame(k + 1, 50 + k)); end
         tick();
         expState = (k == 4) ? 2'd2 : 2'd1;
         checks++; if (state !== expState) begin failures++; $display("[TB] FAIL drain_state%0d got=%0d exp=%0d", k, state, expState); end
      end
      checks++; if (done !== 1'b1 || level !== 5'd0) begin failures++; $display("[TB] FAIL drain_done got=%b/%0d exp=1/0", done, level); end
      repeat (3) tick();
      checks++; if (state !== 2'd2 || level !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL done_terminal got=%0d/%0d/%b exp=2/0/0", state, level, out_valid); end
      dct_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_saturate();
      doReset();
      pushFrames(22, 200);
      checks++; if (drop_count !== 8'd6) begin failures++; $display("[TB] FAIL sat_wide got=%0d exp=6", drop_count); end
      checks++; if (drop_count2 !== 2'd3 || overflow2 !== 1'b1) begin failures++; $display("[TB] FAIL sat_narrow got=%0d/%b exp=3/1", drop_count2, overflow2); end
      dct_valid = 1'b1;
      dct_count = 4'd0;
      repeat (4) tick();
      dct_valid = 1'b0;
      checks++; if (drop_count !== 8'd6) begin failures++; $display("[TB] FAIL sat_zero_nodrop got=%0d exp=6", drop_count); end
   endtask

   task automatic test_zero_count();
      doReset();
      dct_valid  = 1'b1;
      dct_count  = 4'd0;
      dct_buffer = DCT_W'('h55);
      repeat (3) tick();
      dct_valid = 1'b0;
      checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL zero_nopush got=%0d/%b exp=0/0", level, out_valid); end
      checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("[TB] FAIL zero_nodrop got=%b/%0d exp=0/0", overflow, drop_count); end
   endtask

   task automatic test_reset_mid();
      doReset();
      pushFrames(20, 300);
      out_ready = 1'b1;
      repeat (9) tick();
      out_ready   = 1'b0;
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      checks++; if (state !== 2'd1 || level !== 5'd7 || overflow !== 1'b1) begin failures++; $display("[TB] FAIL mid_setup got=%0d/%0d/%b exp=1/7/1", state, level, overflow); end
      reset_n   = 1'b0;
      out_ready = 1'b1;
      dct_valid = 1'b1;
      dct_count = 4'd3;
      tick();
      reset_n   = 1'b1;
      dct_valid = 1'b0;
      out_ready = 1'b0;
      checks++; if (state !== 2'd0 || level !== 5'd0) begin failures++; $display("[TB] FAIL mid_cleared got=%0d/%0d exp=0/0", state, level); end
      checks++; if (overflow !== 1'b0 || drop_count !== 8'd0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mid_flags got=%b/%0d/%b exp=0/0/0", overflow, drop_count, done); end
      checks++; if (out_valid !== 1'b0 || out_data !== '0) begin failures++; $display("[TB] FAIL mid_head got=%b/%h exp=0/0", out_valid, out_data); end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_pushpop();
      test_drain();
      test_saturate();
      test_zero_count();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nios2_oci_trace_capture.md
NIOS2_OCI_TRACE_CAPTURE -- requirements
Module: nios2_oci_trace_capture

Interface
REQ-001 Parameter DCT_W, default 30: width of the debug capture trace word.
REQ-002 Parameter CNT_W, default 4: width of the dct_count field.
REQ-003 Parameter DEPTH, default 16: number of FIFO frame entries; SHALL be a power of 2, at least 2.
REQ-004 Parameter OVF_W, default 8: width of the overflow drop counter.
REQ-005 clk  in  1  single clock for the block.
REQ-006 reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 dct_buffer  in  DCT_W  trace payload word.
REQ-008 dct_count  in  CNT_W  number of valid slots in dct_buffer.
REQ-009 dct_valid  in  1  qualifies dct_buffer and dct_count in this cycle.
REQ-010 test_ending  in  1  request to stop capturing new frames.
REQ-011 test_has_ended  in  1  test complete; drain the FIFO, then signal done.
REQ-012 out_valid  out  1  head frame is available.
REQ-013 out_ready  in  1  consumer accepts the head frame.
REQ-014 out_data  out  CNT_W+DCT_W  head frame as {count, buffer}.
REQ-015 level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-016 overflow  out  1  sticky flag: at least one frame has been dropped.
REQ-017 drop_count  out  OVF_W  number of dropped frames; saturates at all-ones.
REQ-018 state  out  2  FSM state: CAPTURE=0, DRAIN=1, DONE=2.
REQ-019 done  out  1  high only in the DONE state.

Function
REQ-020 Push condition: dct_valid=1 AND dct_count!=0 AND state=CAPTURE; the frame written is {dct_count, dct_buffer}.
REQ-021 A frame with dct_count=0 SHALL be ignored: no push and no drop.
REQ-022 Pop condition: out_valid=1 AND out_ready=1 in the same cycle.
REQ-023 out_valid SHALL equal (level != 0); out_data SHALL equal the head entry; both are stable while out_ready=0.
REQ-024 Latency: a frame pushed at edge N SHALL appear at the head by edge N+1 at the earliest; there is no same-cycle fall-through.
REQ-025 When the FIFO is full and no pop occurs, a push attempt SHALL be dropped, set overflow, and increment drop_count (saturating).
REQ-026 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted and level SHALL stay at DEPTH.
REQ-027 Simultaneous push and pop on a non-empty FIFO SHALL leave level unchanged and preserve order.
REQ-028 Pointers SHALL wrap modulo DEPTH; level SHALL distinguish full (DEPTH) from empty (0).
REQ-029 FSM CAPTURE -> DRAIN when test_ending=1 or test_has_ended=1; a push in that same cycle SHALL still be accepted.
REQ-030 FSM DRAIN -> DONE when test_has_ended has been seen (latched, sticky) AND level=0 after any pop in the current cycle.
REQ-031 FSM DRAIN SHALL remain in DRAIN while level>0 or test_has_ended has not yet been seen; dct_valid SHALL be ignored in DRAIN.
REQ-032 FSM DONE is terminal until reset: no pushes, out_valid=0, done=1.
REQ-033 overflow and drop_count SHALL hold their values in all states until reset.

Reset
REQ-034 On reset_n=0 at a clock edge: state=CAPTURE, level=0, out_valid=0, out_data=0, overflow=0, drop_count=0, done=0, ended latch=0, pointers=0.
REQ-035 Reset mid-operation SHALL discard all FIFO contents; a push or pop in the reset cycle SHALL have no effect.
REQ-036 FIFO storage need not be cleared, but out_data SHALL read 0 whenever out_valid=0.

Verification
REQ-037 Push 3 frames (count=1,2,3; buffer=0x1,0x2,0x3), out_ready=0 -> level=3, out_data={1,0x1}; then out_ready=1 for 3 cycles -> frames pop in order, level=0.
REQ-038 DEPTH=16, out_ready=0, push 20 valid frames -> level=16, overflow=1, drop_count=4; the first 16 frames are retained in order.
REQ-039 FIFO full, push and pop in the same cycle -> level stays 16, the new frame becomes the tail, drop_count unchanged.
REQ-040 5 frames queued, pulse test_ending, keep dct_valid=1 -> state=DRAIN, no new pushes; pulse test_has_ended, drain 5 frames -> DONE on the cycle level reaches 0, done=1.
REQ-041 OVF_W=2, 6 drops -> drop_count=3 (saturated); dct_count=0 frames -> no push and no drop.
REQ-042 reset_n=0 for one cycle during DRAIN with level=7 -> next cycle state=CAPTURE, level=0, overflow=0, done=0.
